awgn_stats_monitor: RTL and testbench

Consumer end of the Box-Muller AWGN generator interface. It accepts the generator's valid-qualified sample pair stream (v, x0, x1) and accumulates statistics over a programmable window of sample pairs: sum, sum of squares, peak magnitude and over-threshold count. Firmware or a bench uses these to check noise mean and variance without capturing raw samples. It sits directly on the generator outputs and adds no backpressure.

---
 rtl/awgn_stats_monitor.sv | 181 ++++++++++++++++++
 tb/tb_awgn_stats_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/awgn_stats_monitor.sv
// Windowed statistics on the AWGN generator's sample-pair stream: sum, sum of
// squares, peak magnitude and over-threshold count over n_pairs accepted pairs.
module awgn_stats_monitor #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_W-1:0]          n_pairs,
    input  logic [DW-1:0]             thresh,
    input  logic                      v,
    input  logic signed [DW-1:0]      x0,
    input  logic signed [DW-1:0]      x1,
    output logic                      busy,
    output logic                      done,
    output logic signed [DW+CNT_W:0]  sum,
    output logic [2*DW+CNT_W-1:0]     sumsq,
    output logic [DW-1:0]             peak,
    output logic [CNT_W:0]            over_cnt
);

    localparam int SW  = DW + CNT_W + 1;
    localparam int SQW = 2 * DW + CNT_W;
    localparam int OW  = CNT_W + 1;
    localparam int PW  = 2 * DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [DW-1:0]          thr_q, thr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   p0_vld_q, p0_vld_d;
    logic                   p0_last_q, p0_last_d;
    logic signed [DW-1:0]   p0_x0_q, p0_x0_d;
    logic signed [DW-1:0]   p0_x1_q, p0_x1_d;

    logic                   p1_vld_q, p1_vld_d;
    logic                   p1_last_q, p1_last_d;
    logic signed [DW-1:0]   p1_x0_q, p1_x0_d;
    logic signed [DW-1:0]   p1_x1_q, p1_x1_d;
    logic [DW-1:0]          p1_a0_q, p1_a0_d;
    logic [DW-1:0]          p1_a1_q, p1_a1_d;
    logic [PW-1:0]          p1_sq0_q, p1_sq0_d;
    logic [PW-1:0]          p1_sq1_q, p1_sq1_d;

    logic signed [SW-1:0]   sum_q, sum_d;
    logic [SQW-1:0]         sumsq_q, sumsq_d;
    logic [DW-1:0]          peak_q, peak_d;
    logic [OW-1:0]          over_q, over_d;

    logic                   start_ok;
    logic                   accept;
    logic [CNT_W-1:0]       cnt_inc;
    logic signed [PW-1:0]   sq0_s;
    logic signed [PW-1:0]   sq1_s;
    logic [DW-1:0]          pair_max;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        thr_d     = thr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sumsq_d   = sumsq_q;
        peak_d    = peak_q;
        over_d    = over_q;

        start_ok  = start && (state_q == IDLE || state_q == DONE);
        accept    = (state_q == RUN) && v;
        cnt_inc   = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = n_pairs;
                    thr_d   = thresh;
                    cnt_d   = '0;
                    state_d = (n_pairs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (p1_vld_q && p1_last_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Stage 0 captures the pair; the last-pair flag rides alongside so
        // DONE lands on the same edge as the final accumulator update.
        p0_vld_d  = accept;
        p0_last_d = accept && (cnt_inc == n_q);
        p0_x0_d   = accept ? x0 : p0_x0_q;
        p0_x1_d   = accept ? x1 : p0_x1_q;

        sq0_s     = PW'(p0_x0_q) * PW'(p0_x0_q);
        sq1_s     = PW'(p0_x1_q) * PW'(p0_x1_q);
        p1_vld_d  = p0_vld_q;
        p1_last_d = p0_last_q;
        p1_x0_d   = p0_x0_q;
        p1_x1_d   = p0_x1_q;
        p1_a0_d   = p0_x0_q[DW-1] ? $unsigned(-p0_x0_q) : $unsigned(p0_x0_q);
        p1_a1_d   = p0_x1_q[DW-1] ? $unsigned(-p0_x1_q) : $unsigned(p0_x1_q);
        p1_sq0_d  = $unsigned(sq0_s);
        p1_sq1_d  = $unsigned(sq1_s);

        pair_max  = (p1_a0_q > p1_a1_q) ? p1_a0_q : p1_a1_q;
        if (start_ok) begin
            sum_d   = '0;
            sumsq_d = '0;
            peak_d  = '0;
            over_d  = '0;
        end else if (p1_vld_q) begin
            sum_d   = sum_q + SW'(p1_x0_q) + SW'(p1_x1_q);
            sumsq_d = sumsq_q + SQW'(p1_sq0_q) + SQW'(p1_sq1_q);
            if (pair_max > peak_q) peak_d = pair_max;
            over_d  = over_q + OW'(p1_a0_q > thr_q) + OW'(p1_a1_q > thr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            thr_q     <= '0;
            cnt_q     <= '0;
            p0_vld_q  <= 1'b0;
            p0_last_q <= 1'b0;
            p0_x0_q   <= '0;
            p0_x1_q   <= '0;
            p1_vld_q  <= 1'b0;
            p1_last_q <= 1'b0;
            p1_x0_q   <= '0;
            p1_x1_q   <= '0;
            p1_a0_q   <= '0;
            p1_a1_q   <= '0;
            p1_sq0_q  <= '0;
            p1_sq1_q  <= '0;
            sum_q     <= '0;
            sumsq_q   <= '0;
            peak_q    <= '0;
            over_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            thr_q     <= thr_d;
            cnt_q     <= cnt_d;
            p0_vld_q  <= p0_vld_d;
            p0_last_q <= p0_last_d;
            p0_x0_q   <= p0_x0_d;
            p0_x1_q   <= p0_x1_d;
            p1_vld_q  <= p1_vld_d;
            p1_last_q <= p1_last_d;
            p1_x0_q   <= p1_x0_d;
            p1_x1_q   <= p1_x1_d;
            p1_a0_q   <= p1_a0_d;
            p1_a1_q   <= p1_a1_d;
            p1_sq0_q  <= p1_sq0_d;
            p1_sq1_q  <= p1_sq1_d;
            sum_q     <= sum_d;
            sumsq_q   <= sumsq_d;
            peak_q    <= peak_d;
            over_q    <= over_d;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign sumsq    = sumsq_q;
    assign peak     = peak_q;
    assign over_cnt = over_q;

endmodule

// File: tb/tb_awgn_stats_monitor.sv
// Scoreboard bench for awgn_stats_monitor: expected window results are queued
// as pairs are driven and checked when done rises.
module tb_awgn_stats_monitor;

    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [CNT_W-1:0]          n_pairs;
    logic [DW-1:0]             thresh;
    logic                      v;
    logic signed [DW-1:0]      x0;
    logic signed [DW-1:0]      x1;
    logic                      busy;
    logic                      done;
    logic signed [DW+CNT_W:0]  sum;
    logic [2*DW+CNT_W-1:0]     sumsq;
    logic [DW-1:0]             peak;
    logic [CNT_W:0]            over_cnt;

    awgn_stats_monitor #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .n_pairs(n_pairs),
        .thresh(thresh), .v(v), .x0(x0), .x1(x1), .busy(busy), .done(done),
        .sum(sum), .sumsq(sumsq), .peak(peak), .over_cnt(over_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        longint sumsq;
        longint peak;
        longint over;
        longint edge_no;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint ecnt = 0;
    int     done_events = 0;
    int     want = 0;
    logic   done_prev = 1'b0;

    longint m_sum, m_sumsq, m_peak, m_over, m_thresh;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) ecnt <= ecnt + 1;

    // Scoreboard consumer: one expected window per rising edge of done.
    always @(negedge clk) begin
        if (reset && done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", longint'(sum), e.sum);
                chk("sumsq", longint'(sumsq), e.sumsq);
                chk("peak", longint'(peak), e.peak);
                chk("over_cnt", longint'(over_cnt), e.over);
                chk("done_edge", ecnt, e.edge_no);
            end
            done_events++;
        end
        if (busy && done) chk("busy_done_exclusive", 1, 0);
        done_prev = done;
    end

    function automatic longint mag(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_add(input int a, input int b);
        m_sum   += longint'(a) + longint'(b);
        m_sumsq += longint'(a) * longint'(a) + longint'(b) * longint'(b);
        if (mag(a) > m_peak) m_peak = mag(a);
        if (mag(b) > m_peak) m_peak = mag(b);
        if (mag(a) > m_thresh) m_over++;
        if (mag(b) > m_thresh) m_over++;
    endtask

    task automatic push_exp(input longint edge_no);
        exp_t x;
        x.sum = m_sum; x.sumsq = m_sumsq; x.peak = m_peak; x.over = m_over;
        x.edge_no = edge_no;
        sb.push_back(x);
    endtask

    task automatic drive(input bit s, input bit vv, input int a, input int b);
        @(negedge clk);
        start = s; v = vv; x0 = DW'(a); x1 = DW'(b);
    endtask

    task automatic start_win(input int n, input int th, input bit vv, input int a, input int b);
        @(negedge clk);
        n_pairs = CNT_W'(n); thresh = DW'(th);
        start = 1'b1; v = vv; x0 = DW'(a); x1 = DW'(b);
        m_sum = 0; m_sumsq = 0; m_peak = 0; m_over = 0; m_thresh = th;
        if (n == 0) push_exp(ecnt + 1);
    endtask

    task automatic send_pair(input int a, input int b, input bit last);
        drive(1'b0, 1'b1, a, b);
        model_add(a, b);
        if (last) push_exp(ecnt + 3);
    endtask

    task automatic wait_done();
        want++;
        for (int k = 0; k < 40 && done_events < want; k++) @(posedge clk);
        chk("done_seen", done_events, want);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_sum"}, longint'(sum), 0);
        chk({pfx, "_sumsq"}, longint'(sumsq), 0);
        chk({pfx, "_peak"}, longint'(peak), 0);
        chk({pfx, "_over"}, longint'(over_cnt), 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; v = 1'b0; x0 = '0; x1 = '0;
        n_pairs = '0; thresh = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;

        // Empty window straight from IDLE.
        start_win(0, 0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        chk("n0_done", done, 1);
        chk("n0_busy", busy, 0);
        chk("n0_sum", longint'(sum), 0);
        wait_done();

        // Mixed pairs including the most negative sample.
        start_win(4, 50, 1'b0, 0, 0);
        send_pair(1, 2, 1'b0);
        send_pair(-3, 4, 1'b0);
        send_pair(100, -100, 1'b0);
        send_pair(-32768, 32767, 1'b1);
        drive(1'b0, 1'b0, 0, 0);
        wait_done();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 123, -77);
        chk("hold_sum", longint'(sum), 3);
        chk("hold_sumsq", longint'(sumsq), 64'd2147438143);
        chk("hold_peak", longint'(peak), 32768);
        chk("hold_over", longint'(over_cnt), 4);
        chk("hold_done", done, 1);

        // Sparse valid plus one pair past the window end.
        start_win(3, 10, 1'b0, 0, 0);
        send_pair(10, 10, 1'b0);
        drive(1'b0, 1'b0, 0, 0);
        send_pair(10, 10, 1'b0);
        drive(1'b0, 1'b0, 0, 0);
        send_pair(10, 10, 1'b1);
        drive(1'b0, 1'b1, 10, 10);
        drive(1'b0, 1'b0, 0, 0);
        wait_done();

        // start while busy must not restart or resize the window.
        start_win(2, 0, 1'b0, 0, 0);
        send_pair(3, 4, 1'b0);
        n_pairs = CNT_W'(5);
        drive(1'b1, 1'b0, 0, 0);
        send_pair(5, 6, 1'b1);
        drive(1'b0, 1'b0, 0, 0);
        wait_done();
        chk("busy_start_idle", busy, 0);

        // Asynchronous reset mid-window abandons it.
        start_win(5, 50, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1, 1);
        drive(1'b0, 1'b1, 2, 2);
        drive(1'b0, 1'b0, 0, 0);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;

        // Pair presented with start from IDLE is not counted.
        start_win(1, 5, 1'b1, 999, 999);
        send_pair(-5, 5, 1'b1);
        drive(1'b0, 1'b0, 0, 0);
        wait_done();

        // Restart from DONE: done drops and accumulators rebuild from zero.
        start_win(2, 100, 1'b0, 0, 0);
        send_pair(7, -7, 1'b0);
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_sum", longint'(sum), 0);
        chk("restart_peak", longint'(peak), 0);
        send_pair(7, -7, 1'b1);
        drive(1'b0, 1'b0, 0, 0);
        wait_done();

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
